vec_alu_multilane: RTL and testbench

Multi-lane, vl/mask-aware vector integer ALU: the next generation of the single-lane `vec_alu`. One instance contains `2^NB_LANES` lanes of `2^LANE_WIDTH` bits each. It processes one contiguous chunk of the operand registers per cycle and carries add/sub state across chunks when an element is wider than a chunk. It sits between the vector register file read port and the writeback port, and supports `vl` tail handling, `v0` masking and several opcodes.

---
 rtl/vec_alu_multilane.sv | 235 +++++++++++++++++++++++
 tb/tb_vec_alu_multilane.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vec_alu_multilane.sv
// vec_alu_multilane
//   Multi-lane vector integer ALU with vl tail handling and v0 masking. It
//   walks the operand registers one DW-bit chunk per cycle, where
//   DW = 2^NB_LANES * 2^LANE_WIDTH. Elements no wider than a chunk are
//   computed whole. Elements wider than a chunk take several cycles, with a
//   registered carry/borrow chained between their chunks.
//
// Ports
//   clk, resetn     : rising-edge clock, synchronous active-low reset
//   run             : start request, only looked at while idle
//   opcode, vsew    : funct6 operation and element width (SEW = 8 << vsew)
//   vl, vm, mask    : active element count, unmasked flag, v0 mask bits
//   vs1, vs2        : source registers (vsub computes vs2 - vs1)
//   vd_old          : prior destination, kept in tail and masked-off elements
//   vd              : result register, holds until the next start
//   reg_index       : bit offset of the chunk being written while busy
//   busy, done      : busy while chunks are processed, done pulses once
//   illegal         : alongside done, flags an unsupported opcode/vsew
module vec_alu_multilane #(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 4,
  parameter int NB_LANES   = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            run,
  input  logic [5:0]      opcode,
  input  logic [2:0]      vsew,
  input  logic [10:0]     vl,
  input  logic            vm,
  input  logic [VLEN-1:0] mask,
  input  logic [VLEN-1:0] vs1,
  input  logic [VLEN-1:0] vs2,
  input  logic [VLEN-1:0] vd_old,
  output logic [VLEN-1:0] vd,
  output logic [9:0]      reg_index,
  output logic            busy,
  output logic            done,
  output logic            illegal
);

  localparam int DW  = (1 << NB_LANES) * (1 << LANE_WIDTH);
  localparam int NCH = VLEN / DW;
  localparam int KW  = $clog2(NCH) + 1;
  localparam int IW  = $clog2(VLEN);

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_AND  = 6'b001001;
  localparam logic [5:0] OP_OR   = 6'b001010;
  localparam logic [5:0] OP_XOR  = 6'b001011;
  localparam logic [5:0] OP_MINU = 6'b000100;
  localparam logic [5:0] OP_MAXU = 6'b000110;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [5:0]      op_q;
  logic [1:0]      sew_q;
  logic [10:0]     vl_q;
  logic            vm_q;
  logic [VLEN-1:0] mask_q, vs1_q, vs2_q;
  logic [KW-1:0]   k_q, last_k_q;
  logic            carry_q, illegal_q;

  logic            op_known, op_minmax, start_illegal, start_skip;
  logic [10:0]     vlmax, vl_eff;
  logic [31:0]     n_bits;
  logic [KW-1:0]   start_last_k;

  logic [IW-1:0]   chunk_off;
  logic [DW-1:0]   a_chunk, b_chunk, old_chunk, res, wen, merged;
  logic            carry_next;
  logic [3:0][DW-1:0] res_s, wen_s;
  logic [3:0]      cnext_s;

  // One element operation, evaluated on zero-extended operands and truncated
  // by the caller, so add/sub wrap modulo 2^SEW and min/max stay unsigned.
  function automatic logic [63:0] elem_op(input logic [5:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    case (op)
      OP_ADD:  elem_op = b + a;
      OP_SUB:  elem_op = b - a;
      OP_AND:  elem_op = b & a;
      OP_OR:   elem_op = b | a;
      OP_XOR:  elem_op = b ^ a;
      OP_MINU: elem_op = (a < b) ? a : b;
      OP_MAXU: elem_op = (a > b) ? a : b;
      default: elem_op = '0;
    endcase
  endfunction

  // Decode of a start request: is the opcode/width supported, is there
  // anything to do, and how many chunks does the clamped vl cover. Min/max
  // has no carry chain, so it cannot work on elements that span chunks.
  always_comb begin
    op_known      = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND) ||
                    (opcode == OP_OR) || (opcode == OP_XOR) || (opcode == OP_MINU) ||
                    (opcode == OP_MAXU);
    op_minmax     = (opcode == OP_MINU) || (opcode == OP_MAXU);
    start_illegal = vsew[2] || !op_known ||
                    (op_minmax && ((32'd8 << vsew[1:0]) > 32'(DW)));
    start_skip    = start_illegal || (vl == 11'd0);
    vlmax         = 11'(32'(VLEN) >> (32'd3 + 32'(vsew[1:0])));
    vl_eff        = (vl > vlmax) ? vlmax : vl;
    n_bits        = 32'(vl_eff) << (32'd3 + 32'(vsew[1:0]));
    start_last_k  = KW'((n_bits + 32'(DW - 1)) / 32'(DW) - 32'd1);
  end

  assign chunk_off = IW'(int'(k_q) * DW);
  assign a_chunk   = vs1_q[chunk_off +: DW];
  assign b_chunk   = vs2_q[chunk_off +: DW];
  assign old_chunk = vd[chunk_off +: DW];

  // One datapath per element width. Narrow widths split the chunk into
  // whole elements with their own mask/tail enables. Wide widths treat the
  // chunk as one slice of a single element, which sets the carry chain and
  // clears it after the element's last slice.
  for (genvar s = 0; s < 4; s++) begin : g_sew
    localparam int SEW = 8 << s;
    if (SEW <= DW) begin : g_packed
      localparam int EPC = DW / SEW;
      for (genvar j = 0; j < EPC; j++) begin : g_elem
        logic [10:0] idx;
        logic        en;
        assign idx = 11'(int'(k_q) * EPC + j);
        assign en  = (idx < vl_q) && (vm_q || mask_q[idx[IW-1:0]]);
        assign res_s[s][j*SEW +: SEW] = SEW'(elem_op(op_q, 64'(a_chunk[j*SEW +: SEW]),
                                                     64'(b_chunk[j*SEW +: SEW])));
        assign wen_s[s][j*SEW +: SEW] = {SEW{en}};
      end
      assign cnext_s[s] = 1'b0;
    end else begin : g_split
      localparam int CPE = SEW / DW;
      logic [10:0] idx;
      logic        en, last;
      logic [DW:0] sum, diff;
      assign idx  = 11'(int'(k_q) / CPE);
      assign last = (int'(k_q) % CPE) == (CPE - 1);
      assign en   = (idx < vl_q) && (vm_q || mask_q[idx[IW-1:0]]);
      assign sum  = {1'b0, b_chunk} + {1'b0, a_chunk} + {{DW{1'b0}}, carry_q};
      assign diff = {1'b0, b_chunk} - {1'b0, a_chunk} - {{DW{1'b0}}, carry_q};
      assign res_s[s] = (op_q == OP_ADD) ? sum[DW-1:0] :
                        (op_q == OP_SUB) ? diff[DW-1:0] :
                        DW'(elem_op(op_q, 64'(a_chunk), 64'(b_chunk)));
      assign wen_s[s] = {DW{en}};
      assign cnext_s[s] = last ? 1'b0 :
                          (op_q == OP_ADD) ? sum[DW] :
                          (op_q == OP_SUB) ? diff[DW] : 1'b0;
    end
  end

  assign res        = res_s[sew_q];
  assign wen        = wen_s[sew_q];
  assign carry_next = cnext_s[sew_q];
  assign merged     = (old_chunk & ~wen) | (res & wen);

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign illegal   = illegal_q;
  assign reg_index = (state_q == RUN) ? 10'(chunk_off) : 10'd0;

  // State register for the IDLE/RUN/DONE controller.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A start either goes straight to DONE, when there is
  // nothing legal to compute, or walks chunks until the last one. A run
  // request outside IDLE has no effect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run) state_d = start_skip ? DONE : RUN;
      RUN:     if (k_q == last_k_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on start, then one chunk merge into vd per RUN cycle.
  // vd is seeded from vd_old so untouched elements stay undisturbed.
  // illegal is only raised on the direct-to-DONE path and drops on leaving DONE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vd        <= '0;
      op_q      <= '0;
      sew_q     <= '0;
      vl_q      <= '0;
      vm_q      <= 1'b0;
      mask_q    <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      k_q       <= '0;
      last_k_q  <= '0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            op_q      <= opcode;
            sew_q     <= vsew[1:0];
            vl_q      <= vl_eff;
            vm_q      <= vm;
            mask_q    <= mask;
            vs1_q     <= vs1;
            vs2_q     <= vs2;
            vd        <= vd_old;
            k_q       <= '0;
            last_k_q  <= start_last_k;
            carry_q   <= 1'b0;
            illegal_q <= start_illegal;
          end
        end
        RUN: begin
          vd[chunk_off +: DW] <= merged;
          carry_q <= carry_next;
          if (k_q != last_k_q) k_q <= k_q + KW'(1);
        end
        DONE: begin
          illegal_q <= 1'b0;
        end
        default: begin
          illegal_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_alu_multilane.sv
// tb_vec_alu_multilane
//   Testbench for vec_alu_multilane at its default size (VLEN=128, DW=32).
//   Each result is compared with an element-by-element model of the vector
//   operation. The bench covers directed cases, run-while-busy, a reset
//   abort and randomized starts.
module tb_vec_alu_multilane;

  localparam int VLEN = 128;
  localparam int DW   = 32;

  logic            clk = 1'b0;
  logic            resetn, run, vm;
  logic [5:0]      opcode;
  logic [2:0]      vsew;
  logic [10:0]     vl;
  logic [VLEN-1:0] mask, vs1, vs2, vd_old, vd;
  logic [9:0]      reg_index;
  logic            busy, done, illegal;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [127:0] VS1_A = 128'habcdabcdbeefbeef1234567887654321;
  localparam logic [127:0] VS2_A = 128'h8765432112345678beefbeefabcdabcd;
  localparam logic [127:0] AND_A = 128'h83450301122416681224166883450301;

  vec_alu_multilane #(.VLEN(VLEN), .LANE_WIDTH(4), .NB_LANES(1)) dut (
    .clk(clk), .resetn(resetn), .run(run), .opcode(opcode), .vsew(vsew), .vl(vl),
    .vm(vm), .mask(mask), .vs1(vs1), .vs2(vs2), .vd_old(vd_old), .vd(vd),
    .reg_index(reg_index), .busy(busy), .done(done), .illegal(illegal)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Counts every comparison and reports any that disagree.
  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour: decide legality, clamp vl and apply the operation
  // element by element with plain modular arithmetic.
  task automatic modelExpect(input logic [5:0] op, input logic [2:0] sew, input int vlv,
                             input logic vmv, input logic [127:0] msk, input logic [127:0] s1,
                             input logic [127:0] s2, input logic [127:0] old,
                             output logic [127:0] evd, output int elat, output logic eill,
                             output int en);
    int sewb, vle;
    logic [127:0] emask, er;
    longint unsigned x, y, r;
    sewb = 8 << sew[1:0];
    eill = (sew > 3'd3) || !(op inside {6'b000000, 6'b000010, 6'b001001, 6'b001010,
                                        6'b001011, 6'b000100, 6'b000110});
    if ((op == 6'b000100 || op == 6'b000110) && sewb > DW) eill = 1'b1;
    evd  = old;
    en   = 0;
    elat = 1;
    if (!eill && vlv != 0) begin
      vle   = (vlv < VLEN / sewb) ? vlv : VLEN / sewb;
      en    = (vle * sewb + DW - 1) / DW;
      elat  = en + 1;
      emask = (sewb == 64) ? {64'd0, {64{1'b1}}} : ((128'd1 << sewb) - 128'd1);
      for (int i = 0; i < vle; i++) begin
        if (vmv || msk[i]) begin
          x = 64'((s1 >> (i * sewb)) & emask);
          y = 64'((s2 >> (i * sewb)) & emask);
          case (op)
            6'b000000: r = y + x;
            6'b000010: r = y - x;
            6'b001001: r = y & x;
            6'b001010: r = y | x;
            6'b001011: r = y ^ x;
            6'b000100: r = (x < y) ? x : y;
            6'b000110: r = (x > y) ? x : y;
            default:   r = 64'd0;
          endcase
          er  = 128'(r) & emask;
          evd = (evd & ~(emask << (i * sewb))) | (er << (i * sewb));
        end
      end
    end
  endtask

  // Launches one operation and follows it to done, checking reg_index on
  // every busy cycle, then latency, busy length, illegal and vd. With poke
  // set, run is raised again during the second cycle after the start.
  task automatic applyStimulus(input string tag, input logic [5:0] op, input logic [2:0] sew,
                               input logic [10:0] vlv, input logic vmv, input logic [127:0] msk,
                               input logic [127:0] s1, input logic [127:0] s2,
                               input logic [127:0] old, input bit poke);
    logic [127:0] evd;
    logic eill;
    int elat, en, cyc, busy_cnt;
    modelExpect(op, sew, int'(vlv), vmv, msk, s1, s2, old, evd, elat, eill, en);
    @(negedge clk);
    checkOutput({tag, "/done_pulse"}, 128'(done), 128'(0));
    checkOutput({tag, "/illegal_idle"}, 128'(illegal), 128'(0));
    opcode = op; vsew = sew; vl = vlv; vm = vmv;
    mask = msk; vs1 = s1; vs2 = s2; vd_old = old;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    while (!done && cyc < 40) begin
      if (busy) begin
        checkOutput({tag, "/reg_index"}, 128'(reg_index), 128'(busy_cnt * DW));
        busy_cnt++;
      end
      run = (poke && cyc == 2);
      @(negedge clk);
      cyc++;
    end
    run = 1'b0;
    checkOutput({tag, "/done"}, 128'(done), 128'(1));
    checkOutput({tag, "/latency"}, 128'(cyc), 128'(elat));
    checkOutput({tag, "/busy_cycles"}, 128'(busy_cnt), 128'(en));
    checkOutput({tag, "/illegal"}, 128'(illegal), 128'(eill));
    checkOutput({tag, "/vd"}, vd, evd);
  endtask

  // Main sequence: reset, directed cases, reset abort, random starts.
  initial begin
    logic [5:0] ops [8];
    logic [2:0] rsew;
    int sel;
    ops = '{6'b000000, 6'b000010, 6'b001001, 6'b001010, 6'b001011, 6'b000100, 6'b000110,
            6'b111111};
    resetn = 1'b0; run = 1'b0; vm = 1'b1; opcode = '0; vsew = '0; vl = '0;
    mask = '0; vs1 = '0; vs2 = '0; vd_old = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset/vd", vd, 128'd0);
    checkOutput("reset/reg_index", 128'(reg_index), 128'd0);
    checkOutput("reset/busy", 128'(busy), 128'd0);
    checkOutput("reset/done", 128'(done), 128'd0);
    checkOutput("reset/illegal", 128'(illegal), 128'd0);
    resetn = 1'b1;

    applyStimulus("and8", 6'b001001, 3'd0, 11'd16, 1'b1, '0, VS1_A, VS2_A, '1, 1'b0);
    checkOutput("and8/const", vd, AND_A);
    applyStimulus("and16", 6'b001001, 3'd1, 11'd16, 1'b1, '0, VS1_A, VS2_A, '0, 1'b0);
    checkOutput("and16/const", vd, AND_A);
    applyStimulus("and32", 6'b001001, 3'd2, 11'd16, 1'b1, '0, VS1_A, VS2_A, '0, 1'b0);
    checkOutput("and32/const", vd, AND_A);

    applyStimulus("carry", 6'b000000, 3'd3, 11'd2, 1'b1, '0, 128'h00000000ffffffff,
                  128'h1, 128'h5a5a, 1'b0);
    checkOutput("carry/const", vd, 128'h00000000000000000000000100000000);

    applyStimulus("tail", 6'b001001, 3'd0, 11'd5, 1'b1, '0, VS1_A, VS2_A, {16{8'hee}}, 1'b0);
    checkOutput("tail/const", vd, 128'heeeeeeeeeeeeeeeeeeeeee6883450301);

    applyStimulus("mask", 6'b001010, 3'd0, 11'd16, 1'b0, {8{16'h5555}}, '0, {16{8'h11}},
                  {16{8'h22}}, 1'b0);
    checkOutput("mask/const", vd, {8{16'h2211}});

    applyStimulus("badsew", 6'b000000, 3'd4, 11'd4, 1'b1, '0, VS1_A, VS2_A, 128'h77, 1'b0);
    applyStimulus("vl0", 6'b000000, 3'd0, 11'd0, 1'b1, '0, VS1_A, VS2_A, 128'h99, 1'b0);
    applyStimulus("maxu64", 6'b000110, 3'd3, 11'd2, 1'b1, '0, VS1_A, VS2_A, 128'h1, 1'b0);
    applyStimulus("sub64", 6'b000010, 3'd3, 11'd2, 1'b1, '0, 128'h1, 128'h0, 128'h0, 1'b0);
    applyStimulus("poke", 6'b001011, 3'd0, 11'd16, 1'b1, '0, VS1_A, VS2_A, '0, 1'b1);

    @(negedge clk);
    opcode = 6'b001001; vsew = 3'd0; vl = 11'd16; vm = 1'b1;
    vs1 = VS1_A; vs2 = VS2_A; vd_old = '1;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checkOutput("abort/vd", vd, 128'd0);
    checkOutput("abort/busy", 128'(busy), 128'd0);
    checkOutput("abort/done", 128'(done), 128'd0);
    checkOutput("abort/reg_index", 128'(reg_index), 128'd0);
    checkOutput("abort/illegal", 128'(illegal), 128'd0);
    resetn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checkOutput("abort/no_done", 128'(done), 128'd0);
    end
    applyStimulus("restart", 6'b000000, 3'd1, 11'd8, 1'b1, '0, VS1_A, VS2_A, '0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      sel  = $urandom_range(0, 9);
      rsew = (sel > 7) ? 3'(4 + $urandom_range(0, 3)) : 3'(sel % 4);
      applyStimulus("rand", ops[$urandom_range(0, 7)], rsew, 11'($urandom_range(0, 20)),
                    1'($urandom_range(0, 1)),
                    {$urandom(), $urandom(), $urandom(), $urandom()},
                    {$urandom(), $urandom(), $urandom(), $urandom()},
                    {$urandom(), $urandom(), $urandom(), $urandom()},
                    {$urandom(), $urandom(), $urandom(), $urandom()},
                    1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
